// File: rtl/flag_ctrl.sv
// flag_ctrl: flag-register write control, branch condition evaluation and
// flag-hazard stalling for the five-stage pipeline.
//
// Handshake: br_stall is a level, not a valid/ready pair. While it is high the
// ID instruction is held and a bubble enters EX; the branch is resolved in the
// first cycle it drops with the branch still present and not flushed, and the
// registered br_valid pulse (with br_taken/br_reg) follows one cycle later.
module flag_ctrl #(
  parameter bit FWD_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [3:0]  ex_op,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  output logic [2:0]  flag_d,
  output logic [2:0]  flag_e,
  input  logic [2:0]  flag_q,
  input  logic        id_valid,
  input  logic [3:0]  id_op,
  input  logic [2:0]  id_cond,
  input  logic        flush,
  output logic        br_stall,
  output logic        br_valid,
  output logic        br_taken,
  output logic        br_reg,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic        dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_halted;
  logic        r_br_valid;
  logic        r_br_taken;
  logic        r_br_reg;
  logic [15:0] r_stall_cnt;

  logic [2:0]  w_mask;
  logic        w_ex_fire;
  logic        w_id_branch;
  logic [2:0]  w_flags;
  logic        w_cond;
  logic        w_hazard;
  logic        w_resolve;
  logic        w_hlt_retire;

  // Which of {Z,V,N} the EX opcode writes.
  always_comb begin
    w_mask = 3'b000;
    case (ex_op)
      4'b0000, 4'b0001:                   w_mask = 3'b111;  // ADD, SUB
      4'b0010, 4'b0100, 4'b0101, 4'b0110: w_mask = 3'b100;  // XOR, SLL, SRA, ROR
      default:                            w_mask = 3'b000;
    endcase
  end

  assign w_ex_fire    = ex_valid & ~ex_stall & ~r_halted;
  assign flag_d       = {alu_z, alu_v, alu_n};
  assign flag_e       = {3{w_ex_fire}} & w_mask;
  assign w_hlt_retire = ex_valid & ~ex_stall & (ex_op == 4'b1111);

  assign w_id_branch  = id_valid & ((id_op == 4'b1100) | (id_op == 4'b1101)) & ~r_halted;

  // Flags seen by the branch: either the register, or the register with the
  // bits EX is writing this cycle bypassed in.
  always_comb begin
    w_flags = flag_q;
    if (FWD_EN) begin
      w_flags = (flag_e & flag_d) | (~flag_e & flag_q);
    end
  end

  // Branch condition on {Z,V,N}.
  always_comb begin
    w_cond = 1'b0;
    case (id_cond)
      3'b000:  w_cond = ~w_flags[2];
      3'b001:  w_cond = w_flags[2];
      3'b010:  w_cond = ~w_flags[2] & ~w_flags[0];
      3'b011:  w_cond = w_flags[0];
      3'b100:  w_cond = w_flags[2] | (~w_flags[2] & ~w_flags[0]);
      3'b101:  w_cond = w_flags[0] | w_flags[2];
      3'b110:  w_cond = w_flags[1];
      default: w_cond = 1'b1;
    endcase
  end

  // Without forwarding, any flag writer in EX (stalled or not) blocks the branch.
  assign w_hazard  = ~FWD_EN & w_id_branch & ex_valid & (|w_mask) & ~flush;
  assign br_stall  = w_hazard;
  assign w_resolve = w_id_branch & ~w_hazard & ~flush;

  // Next-state: HOLD while the hazard persists, flush always returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  w_state_nxt = w_hazard ? ST_HOLD : ST_RUN;
      ST_HOLD: w_state_nxt = w_hazard ? ST_HOLD : ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
    if (flush) begin
      w_state_nxt = ST_RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // One-cycle branch resolution pulse; taken/reg are zero outside the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_valid <= 1'b0;
      r_br_taken <= 1'b0;
      r_br_reg   <= 1'b0;
    end else begin
      r_br_valid <= w_resolve;
      r_br_taken <= w_resolve & w_cond;
      r_br_reg   <= w_resolve & (id_op == 4'b1101);
    end
  end

  // Sticky halt once HLT leaves EX; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_hlt_retire) begin
      r_halted <= 1'b1;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (br_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign br_valid  = r_br_valid;
  assign br_taken  = r_br_taken;
  assign br_reg    = r_br_reg;
  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed testbench for flag_ctrl: one stall-mode instance and one
// forwarding instance share all inputs.
module tb_flag_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_stall;
  logic [3:0]  ex_op;
  logic        alu_z;
  logic        alu_v;
  logic        alu_n;
  logic [2:0]  flag_q;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [2:0]  id_cond;
  logic        flush;

  logic [2:0]  s_flag_d, f_flag_d;
  logic [2:0]  s_flag_e, f_flag_e;
  logic        s_br_stall, f_br_stall;
  logic        s_br_valid, f_br_valid;
  logic        s_br_taken, f_br_taken;
  logic        s_br_reg, f_br_reg;
  logic        s_halted, f_halted;
  logic [15:0] s_stall_cnt, f_stall_cnt;
  logic        s_state, f_state;

  int n_checks = 0;
  int n_fail   = 0;

  flag_ctrl #(.FWD_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_op(ex_op),
    .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .flag_d(s_flag_d), .flag_e(s_flag_e),
    .flag_q(flag_q), .id_valid(id_valid), .id_op(id_op), .id_cond(id_cond), .flush(flush),
    .br_stall(s_br_stall), .br_valid(s_br_valid), .br_taken(s_br_taken), .br_reg(s_br_reg),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .dbg_state(s_state)
  );

  flag_ctrl #(.FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_op(ex_op),
    .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .flag_d(f_flag_d), .flag_e(f_flag_e),
    .flag_q(flag_q), .id_valid(id_valid), .id_op(id_op), .id_cond(id_cond), .flush(flush),
    .br_stall(f_br_stall), .br_valid(f_br_valid), .br_taken(f_br_taken), .br_reg(f_br_reg),
    .halted(f_halted), .stall_cnt(f_stall_cnt), .dbg_state(f_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_stall = 1'b0; ex_op = 4'b1000;
    alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0; flag_q = 3'b000;
    id_valid = 1'b0; id_op = 4'b0000; id_cond = 3'b000; flush = 1'b0;
  endtask

  // Advance one clock, sampling 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++; if (s_br_valid !== 1'b0) begin n_fail++; $display("FAIL reset_br_valid got=%b exp=0", s_br_valid); end
    n_checks++; if (s_br_taken !== 1'b0) begin n_fail++; $display("FAIL reset_br_taken got=%b exp=0", s_br_taken); end
    n_checks++; if (s_br_reg !== 1'b0) begin n_fail++; $display("FAIL reset_br_reg got=%b exp=0", s_br_reg); end
    n_checks++; if (s_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", s_halted); end
    n_checks++; if (s_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%h exp=0000", s_stall_cnt); end
    n_checks++; if (s_flag_e !== 3'b000) begin n_fail++; $display("FAIL reset_flag_e got=%b exp=000", s_flag_e); end
    n_checks++; if (s_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got=%b exp=RUN", s_state); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_flag_enables();
    logic [2:0] exp_mask [15];
    exp_mask = '{3'b111, 3'b111, 3'b100, 3'b000, 3'b100, 3'b100, 3'b100,
                 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    idle_inputs();
    ex_valid = 1'b1; ex_op = 4'b0001; alu_z = 1'b1; alu_v = 1'b0; alu_n = 1'b1;
    #1;
    n_checks++; if (s_flag_e !== 3'b111) begin n_fail++; $display("FAIL sub_flag_e got=%b exp=111", s_flag_e); end
    n_checks++; if (s_flag_d !== 3'b101) begin n_fail++; $display("FAIL sub_flag_d got=%b exp=101", s_flag_d); end
    ex_op = 4'b0010; #1;
    n_checks++; if (s_flag_e !== 3'b100) begin n_fail++; $display("FAIL xor_flag_e got=%b exp=100", s_flag_e); end
    ex_op = 4'b1000; #1;
    n_checks++; if (s_flag_e !== 3'b000) begin n_fail++; $display("FAIL lw_flag_e got=%b exp=000", s_flag_e); end
    for (int op = 0; op < 15; op++) begin
      ex_op = op[3:0]; #1;
      n_checks++; if (s_flag_e !== exp_mask[op]) begin n_fail++; $display("FAIL op%0d_flag_e got=%b exp=%b", op, s_flag_e, exp_mask[op]); end
    end
    ex_op = 4'b0000; ex_stall = 1'b1; #1;
    n_checks++; if (s_flag_e !== 3'b000) begin n_fail++; $display("FAIL stalled_flag_e got=%b exp=000", s_flag_e); end
    ex_stall = 1'b0; ex_valid = 1'b0; #1;
    n_checks++; if (s_flag_e !== 3'b000) begin n_fail++; $display("FAIL invalid_flag_e got=%b exp=000", s_flag_e); end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    logic [7:0] exp_taken;
    exp_taken = 8'b1011_0010;  // bit c = expected taken for ccc=c
    idle_inputs();
    flag_q = 3'b100;
    id_valid = 1'b1; id_op = 4'b1100;
    for (int c = 0; c < 8; c++) begin
      id_cond = c[2:0];
      #1;
      n_checks++; if (s_br_stall !== 1'b0) begin n_fail++; $display("FAIL cond%0d_stall got=%b exp=0", c, s_br_stall); end
      tick();
      n_checks++; if (s_br_valid !== 1'b1) begin n_fail++; $display("FAIL cond%0d_valid got=%b exp=1", c, s_br_valid); end
      n_checks++; if (s_br_taken !== exp_taken[c]) begin n_fail++; $display("FAIL cond%0d_taken got=%b exp=%b", c, s_br_taken, exp_taken[c]); end
      n_checks++; if (s_br_reg !== 1'b0) begin n_fail++; $display("FAIL cond%0d_reg got=%b exp=0", c, s_br_reg); end
      n_checks++; if (f_br_taken !== exp_taken[c]) begin n_fail++; $display("FAIL cond%0d_fwd_taken got=%b exp=%b", c, f_br_taken, exp_taken[c]); end
    end
    id_valid = 1'b0;
    tick();
    n_checks++; if (s_br_valid !== 1'b0) begin n_fail++; $display("FAIL cond_pulse_end got=%b exp=0", s_br_valid); end
    n_checks++; if (s_br_taken !== 1'b0) begin n_fail++; $display("FAIL cond_taken_clear got=%b exp=0", s_br_taken); end
    idle_inputs();
  endtask

  task automatic test_hazard();
    idle_inputs();
    // ADD producing zero in EX, BR EQ in ID, register still Z=0.
    ex_valid = 1'b1; ex_op = 4'b0000; alu_z = 1'b1;
    id_valid = 1'b1; id_op = 4'b1101; id_cond = 3'b001;
    #1;
    n_checks++; if (s_br_stall !== 1'b1) begin n_fail++; $display("FAIL haz_stall got=%b exp=1", s_br_stall); end
    n_checks++; if (f_br_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_no_stall got=%b exp=0", f_br_stall); end
    tick();
    n_checks++; if (s_state !== 1'b1) begin n_fail++; $display("FAIL haz_state got=%b exp=HOLD", s_state); end
    n_checks++; if (s_br_valid !== 1'b0) begin n_fail++; $display("FAIL haz_no_valid got=%b exp=0", s_br_valid); end
    n_checks++; if (f_br_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid got=%b exp=1", f_br_valid); end
    n_checks++; if (f_br_taken !== 1'b1) begin n_fail++; $display("FAIL fwd_taken got=%b exp=1", f_br_taken); end
    n_checks++; if (f_br_reg !== 1'b1) begin n_fail++; $display("FAIL fwd_reg got=%b exp=1", f_br_reg); end
    // Writer gone, flag register now holds Z=1.
    ex_valid = 1'b0; flag_q = 3'b100;
    #1;
    n_checks++; if (s_br_stall !== 1'b0) begin n_fail++; $display("FAIL haz_release got=%b exp=0", s_br_stall); end
    tick();
    n_checks++; if (s_br_valid !== 1'b1) begin n_fail++; $display("FAIL haz_valid got=%b exp=1", s_br_valid); end
    n_checks++; if (s_br_taken !== 1'b1) begin n_fail++; $display("FAIL haz_taken got=%b exp=1", s_br_taken); end
    n_checks++; if (s_br_reg !== 1'b1) begin n_fail++; $display("FAIL haz_reg got=%b exp=1", s_br_reg); end
    n_checks++; if (s_stall_cnt !== 16'd1) begin n_fail++; $display("FAIL haz_cnt got=%0d exp=1", s_stall_cnt); end
    n_checks++; if (s_state !== 1'b0) begin n_fail++; $display("FAIL haz_run got=%b exp=RUN", s_state); end
    idle_inputs();
    tick();
    n_checks++; if (s_br_valid !== 1'b0) begin n_fail++; $display("FAIL haz_pulse_end got=%b exp=0", s_br_valid); end
  endtask

  task automatic test_back_to_back_stall();
    logic [2:0] exp_fe [3];
    exp_fe = '{3'b000, 3'b000, 3'b111};
    idle_inputs();
    ex_valid = 1'b1; ex_op = 4'b0001; alu_z = 1'b1;
    id_valid = 1'b1; id_op = 4'b1100; id_cond = 3'b001;
    // Two cycles of ex_stall on the writer, then it completes.
    for (int i = 0; i < 3; i++) begin
      ex_stall = (i < 2);
      #1;
      n_checks++; if (s_br_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall%0d got=%b exp=1", i, s_br_stall); end
      n_checks++; if (s_flag_e !== exp_fe[i]) begin n_fail++; $display("FAIL b2b_flag_e%0d got=%b exp=%b", i, s_flag_e, exp_fe[i]); end
      tick();
    end
    ex_stall = 1'b0; ex_valid = 1'b0; flag_q = 3'b100;
    #1;
    n_checks++; if (s_br_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release got=%b exp=0", s_br_stall); end
    tick();
    n_checks++; if (s_br_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", s_br_valid); end
    n_checks++; if (s_br_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_taken got=%b exp=1", s_br_taken); end
    n_checks++; if (s_br_reg !== 1'b0) begin n_fail++; $display("FAIL b2b_reg got=%b exp=0", s_br_reg); end
    n_checks++; if (s_stall_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=4", s_stall_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    ex_valid = 1'b1; ex_op = 4'b0000;
    id_valid = 1'b1; id_op = 4'b1100; id_cond = 3'b111;
    tick();
    n_checks++; if (s_state !== 1'b1) begin n_fail++; $display("FAIL flush_hold got=%b exp=HOLD", s_state); end
    ex_stall = 1'b1; flush = 1'b1;
    #1;
    n_checks++; if (s_br_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", s_br_stall); end
    tick();
    n_checks++; if (s_state !== 1'b0) begin n_fail++; $display("FAIL flush_run got=%b exp=RUN", s_state); end
    n_checks++; if (s_br_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", s_br_valid); end
    n_checks++; if (f_br_valid !== 1'b0) begin n_fail++; $display("FAIL flush_fwd_valid got=%b exp=0", f_br_valid); end
    n_checks++; if (s_stall_cnt !== 16'd5) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=5", s_stall_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_hold();
    idle_inputs();
    ex_valid = 1'b1; ex_op = 4'b0000;
    id_valid = 1'b1; id_op = 4'b1100;
    tick();
    n_checks++; if (s_state !== 1'b1) begin n_fail++; $display("FAIL rsthold_hold got=%b exp=HOLD", s_state); end
    rst = 1'b1;
    #1;
    n_checks++; if (s_state !== 1'b0) begin n_fail++; $display("FAIL rsthold_run got=%b exp=RUN", s_state); end
    n_checks++; if (s_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rsthold_cnt got=%0d exp=0", s_stall_cnt); end
    idle_inputs();
    #1;
    n_checks++; if (s_br_stall !== 1'b0) begin n_fail++; $display("FAIL rsthold_stall got=%b exp=0", s_br_stall); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_halt();
    idle_inputs();
    // HLT retires on the same edge an always-taken B resolves.
    ex_valid = 1'b1; ex_op = 4'b1111;
    id_valid = 1'b1; id_op = 4'b1100; id_cond = 3'b111;
    tick();
    n_checks++; if (s_halted !== 1'b1) begin n_fail++; $display("FAIL hlt_set got=%b exp=1", s_halted); end
    n_checks++; if (s_br_valid !== 1'b1) begin n_fail++; $display("FAIL hlt_same_valid got=%b exp=1", s_br_valid); end
    n_checks++; if (s_br_taken !== 1'b1) begin n_fail++; $display("FAIL hlt_same_taken got=%b exp=1", s_br_taken); end
    ex_op = 4'b0000; alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
    #1;
    n_checks++; if (s_flag_e !== 3'b000) begin n_fail++; $display("FAIL hlt_flag_e got=%b exp=000", s_flag_e); end
    n_checks++; if (s_br_stall !== 1'b0) begin n_fail++; $display("FAIL hlt_stall got=%b exp=0", s_br_stall); end
    tick();
    n_checks++; if (s_br_valid !== 1'b0) begin n_fail++; $display("FAIL hlt_no_valid got=%b exp=0", s_br_valid); end
    n_checks++; if (s_halted !== 1'b1) begin n_fail++; $display("FAIL hlt_sticky got=%b exp=1", s_halted); end
    apply_reset();
    n_checks++; if (s_halted !== 1'b0) begin n_fail++; $display("FAIL hlt_rst_clear got=%b exp=0", s_halted); end
    ex_valid = 1'b1; ex_op = 4'b0000;
    #1;
    n_checks++; if (s_flag_e !== 3'b111) begin n_fail++; $display("FAIL hlt_rst_flag_e got=%b exp=111", s_flag_e); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    ex_valid = 1'b1; ex_op = 4'b0000;
    id_valid = 1'b1; id_op = 4'b1100;
    repeat (65534) tick();
    n_checks++; if (s_stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got=%h exp=FFFE", s_stall_cnt); end
    tick();
    n_checks++; if (s_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=FFFF", s_stall_cnt); end
    repeat (5) tick();
    n_checks++; if (s_stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=FFFF", s_stall_cnt); end
    n_checks++; if (f_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_fwd_cnt got=%h exp=0000", f_stall_cnt); end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_flag_enables();
    test_cond_sweep();
    test_hazard();
    test_back_to_back_stall();
    test_flush();
    test_reset_hold();
    test_halt();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
